pixel_stream_packer: RTL

- Upstream ingest stage of the endmember-extraction datapath.
- Accepts one IN_WIDTH-bit spectral sample per handshake from the sensor/DMA stream and packs CONCAT consecutive bands into one beat. With the defaults this is a 64-bit beat of four 16-bit bands, matching the pixel_in/in_axi_valid port of the extraction top.
- Tracks band and pixel position, zero-pads the final beat of each pixel when SPECTRAL_BANDS is not a multiple of CONCAT, and buffers two beats so back-pressure from the control logic never drops a sample.

---
 rtl/ops_pkg.sv | 30 +++
 rtl/beat_fifo2.sv | 55 +++++
 rtl/pixel_stream_packer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ops_pkg.sv
// Shared types and sizing helpers for the spectral ingest path.
// The packer FSM encoding and counter-width helpers live here so control logic agrees on them.
package ops_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } packer_state_t;

  localparam int DEFAULT_SPECTRAL_BANDS = 188;
  localparam int DEFAULT_IN_WIDTH       = 16;
  localparam int DEFAULT_CONCAT         = 4;
  localparam int DEFAULT_TOTAL_PIXELS   = 47500;

  // Width able to hold 0..n-1; never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beats_per_pixel(input int bands, input int concat);
    return (bands + concat - 1) / concat;
  endfunction

  localparam int BEATS_PER_PIXEL = beats_per_pixel(DEFAULT_SPECTRAL_BANDS, DEFAULT_CONCAT);
  localparam int BAND_W          = cnt_width(DEFAULT_SPECTRAL_BANDS);
  localparam int LANE_W          = cnt_width(DEFAULT_CONCAT);
  localparam int PIXEL_W         = cnt_width(DEFAULT_TOTAL_PIXELS);

endpackage

// File: rtl/beat_fifo2.sv
// Two-entry FIFO for packed beats; the head entry is presented directly on head_data.
// Contents are flops so an asynchronous reset can clear the visible head to zero.
module beat_fifo2 #(
  parameter int WIDTH = 81
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs CONCAT consecutive spectral samples into one beat, zero-padding the last beat of a pixel,
// and tracks band/pixel position through a frame with a two-beat output buffer.
module pixel_stream_packer
  import ops_pkg::*;
#(
  parameter int SPECTRAL_BANDS = 188,
  parameter int IN_WIDTH       = 16,
  parameter int CONCAT         = 4,
  parameter int TOTAL_PIXELS   = 47500
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [IN_WIDTH-1:0]                 s_data,
  input  logic                                s_valid,
  input  logic                                s_last,
  output logic                                s_ready,
  output logic [CONCAT*IN_WIDTH-1:0]          m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                m_last,
  output logic [cnt_width(TOTAL_PIXELS)-1:0]  m_pixel_idx,
  output logic                                frame_done,
  output logic                                busy,
  output logic                                err_last
);

  localparam int LANE_BITS  = cnt_width(CONCAT);
  localparam int BAND_BITS  = cnt_width(SPECTRAL_BANDS);
  localparam int PIXEL_BITS = cnt_width(TOTAL_PIXELS);
  localparam int DATA_W     = CONCAT * IN_WIDTH;
  localparam int ENTRY_W    = 1 + PIXEL_BITS + DATA_W;

  packer_state_t          state_reg, state_next;
  logic [BAND_BITS-1:0]   band_reg;
  logic [LANE_BITS-1:0]   lane_reg;
  logic [PIXEL_BITS-1:0]  pixel_reg;
  logic                   err_last_reg;

  logic                   accept;
  logic                   last_band;
  logic                   last_lane;
  logic                   last_pixel;
  logic                   beat_done;
  logic [DATA_W-1:0]      beat_data;

  logic [ENTRY_W-1:0]     fifo_head;
  logic [1:0]             fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;

  assign accept     = s_valid && s_ready;
  assign last_band  = (band_reg == BAND_BITS'(SPECTRAL_BANDS - 1));
  assign last_lane  = (lane_reg == LANE_BITS'(CONCAT - 1));
  assign last_pixel = (pixel_reg == PIXEL_BITS'(TOTAL_PIXELS - 1));
  assign beat_done  = accept && (last_lane || last_band);

  // Outgoing beat: earlier lanes from the holding registers, the current lane straight
  // from s_data, and any lane beyond the current one forced to zero (pixel-end padding).
  for (genvar gi = 0; gi < CONCAT; gi++) begin : gen_lane
    logic [IN_WIDTH-1:0] sample_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sample_reg <= '0;
      end else if (accept && (lane_reg == LANE_BITS'(gi))) begin
        sample_reg <= s_data;
      end
    end

    assign beat_data[gi*IN_WIDTH +: IN_WIDTH] =
        (lane_reg == LANE_BITS'(gi)) ? s_data :
        (LANE_BITS'(gi) < lane_reg)  ? sample_reg : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        busy    = 1'b1;
        s_ready = !fifo_full;
        if (beat_done && last_band && last_pixel) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // The frame's final beat is the only entry left once the count is down to one.
        frame_done = m_valid && m_ready && (fifo_count == 2'd1);
        if (frame_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      band_reg     <= '0;
      lane_reg     <= '0;
      pixel_reg    <= '0;
      err_last_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (start) begin
        band_reg     <= '0;
        lane_reg     <= '0;
        pixel_reg    <= '0;
        err_last_reg <= 1'b0;
      end
    end else if (accept) begin
      if (s_last != last_band) err_last_reg <= 1'b1;
      lane_reg <= beat_done ? '0 : lane_reg + 1'b1;
      if (last_band) begin
        band_reg  <= '0;
        pixel_reg <= pixel_reg + 1'b1;
      end else begin
        band_reg <= band_reg + 1'b1;
      end
    end
  end

  assign fifo_pop = m_valid && m_ready;

  beat_fifo2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (beat_done),
    .push_data ({last_band, pixel_reg, beat_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid                        = !fifo_empty;
  assign {m_last, m_pixel_idx, m_data}  = fifo_head;
  assign err_last                       = err_last_reg;

endmodule
